// File: rtl/room_fsm.sv
// rtl/room_fsm.sv - room-navigation FSM: synchronized direction presses, room tracking, move count
// Resolves the Dragon's Den from the sword-tracking stage's v flag one edge after entry.

module room_fsm #(
   parameter int SYNC_STAGES = 2,
   parameter int MOVE_W      = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              n,
   input  logic              s,
   input  logic              e,
   input  logic              w,
   input  logic              v,
   output logic              sw,
   output logic [6:0]        room,
   output logic              win,
   output logic              dead,
   output logic [MOVE_W-1:0] moves
);

   typedef enum logic [2:0] {
      CAVE        = 3'd0,
      TUNNEL      = 3'd1,
      RIVER       = 3'd2,
      SWORD_STASH = 3'd3,
      DEN         = 3'd4,
      VAULT       = 3'd5,
      GRAVEYARD   = 3'd6
   } room_t;

   // Direction vectors are ordered {n, s, e, w}.
   localparam int DIR_N = 3;
   localparam int DIR_S = 2;
   localparam int DIR_E = 1;
   localparam int DIR_W = 0;

   logic [3:0]        sync_q [SYNC_STAGES];
   logic [3:0]        prev_q;
   logic [3:0]        press;
   logic              single;
   logic              step;
   room_t             state_q;
   room_t             state_d;
   logic [MOVE_W-1:0] moves_q;

   assign press  = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign single = $onehot(press);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         prev_q  <= '0;
         state_q <= CAVE;
         moves_q <= '0;
      end else begin
         sync_q[0] <= {n, s, e, w};
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         prev_q  <= sync_q[SYNC_STAGES-1];
         state_q <= state_d;
         if (step && (moves_q != {MOVE_W{1'b1}})) begin
            moves_q <= moves_q + 1'b1;
         end
      end
   end

   // Multi-button edges are consumed by prev_q even though no move is taken.
   always_comb begin
      state_d = state_q;
      step    = 1'b0;
      case (state_q)
         CAVE: begin
            if (single && press[DIR_E]) begin
               state_d = TUNNEL;
               step    = 1'b1;
            end
         end
         TUNNEL: begin
            if (single && press[DIR_S]) begin
               state_d = RIVER;
               step    = 1'b1;
            end else if (single && press[DIR_W]) begin
               state_d = CAVE;
               step    = 1'b1;
            end
         end
         RIVER: begin
            if (single && press[DIR_N]) begin
               state_d = TUNNEL;
               step    = 1'b1;
            end else if (single && press[DIR_W]) begin
               state_d = SWORD_STASH;
               step    = 1'b1;
            end else if (single && press[DIR_E]) begin
               state_d = DEN;
               step    = 1'b1;
            end
         end
         SWORD_STASH: begin
            if (single && press[DIR_E]) begin
               state_d = RIVER;
               step    = 1'b1;
            end
         end
         DEN: begin
            state_d = v ? VAULT : GRAVEYARD;
         end
         VAULT, GRAVEYARD: begin
            state_d = state_q;
         end
         default: begin
            state_d = CAVE;
         end
      endcase
   end

   // The unused encoding shifts the bit out and shows an all-zero room for one cycle.
   assign room  = 7'(7'd1 << state_q);
   assign sw    = (state_q == SWORD_STASH);
   assign win   = (state_q == VAULT);
   assign dead  = (state_q == GRAVEYARD);
   assign moves = moves_q;

endmodule

// File: tb/tb_room_fsm.sv
// tb/tb_room_fsm.sv - scoreboard bench for room_fsm with a history-based reference model
// Directed scenarios followed by randomized presses, resets and sword flag values.

module tb_room_fsm;

   localparam int S  = 2;
   localparam int MW = 8;

   localparam int CAVE  = 0;
   localparam int TUN   = 1;
   localparam int RIV   = 2;
   localparam int STASH = 3;
   localparam int DEN   = 4;
   localparam int VAULT = 5;
   localparam int GRAVE = 6;

   logic          clk   = 1'b0;
   logic          reset = 1'b0;
   logic          n = 1'b0, s = 1'b0, e = 1'b0, w = 1'b0, v = 1'b0;
   logic          sw, win, dead;
   logic [6:0]    room;
   logic [MW-1:0] moves;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   room_fsm #(.SYNC_STAGES(S), .MOVE_W(MW)) dut (
      .clk   (clk),
      .reset (reset),
      .n     (n),
      .s     (s),
      .e     (e),
      .w     (w),
      .v     (v),
      .sw    (sw),
      .room  (room),
      .win   (win),
      .dead  (dead),
      .moves (moves)
   );

   typedef struct {
      logic [6:0]    room;
      logic          sw;
      logic          win;
      logic          dead;
      logic [MW-1:0] moves;
   } exp_t;

   exp_t       exp_q[$];
   logic [3:0] hist[$];
   int         m_room  = CAVE;
   int         m_moves = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
   endtask

   // Map of the game: d = 0..3 for n, s, e, w; unlisted moves keep the room.
   function automatic int next_room(input int r, input int d);
      case ({r[3:0], d[1:0]})
         {4'(CAVE),  2'd2}: return TUN;
         {4'(TUN),   2'd1}: return RIV;
         {4'(TUN),   2'd3}: return CAVE;
         {4'(RIV),   2'd0}: return TUN;
         {4'(RIV),   2'd3}: return STASH;
         {4'(RIV),   2'd2}: return DEN;
         {4'(STASH), 2'd2}: return RIV;
         default:           return r;
      endcase
   endfunction

   function automatic void model_reset();
      hist.delete();
      for (int i = 0; i <= S; i++) hist.push_back(4'b0000);
      m_room  = CAVE;
      m_moves = 0;
   endfunction

   function automatic void push_expect();
      exp_t x;
      x.room  = 7'(1 << m_room);
      x.sw    = (m_room == STASH);
      x.win   = (m_room == VAULT);
      x.dead  = (m_room == GRAVE);
      x.moves = MW'(m_moves);
      exp_q.push_back(x);
   endfunction

   // Reference model: level seen at edge t is the input sampled S edges earlier.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         model_reset();
         exp_q.delete();
         push_expect();
      end else begin
         logic [3:0] lvl, prv, pr;
         int         d;
         lvl = hist[1];
         prv = hist[0];
         pr  = lvl & ~prv;
         if (m_room == DEN) begin
            m_room = v ? VAULT : GRAVE;
         end else if ($countones(pr) == 1) begin
            d = 0;
            for (int k = 0; k < 4; k++) if (pr[3-k]) d = k;
            if (next_room(m_room, d) != m_room) begin
               m_room = next_room(m_room, d);
               if (m_moves < (1 << MW) - 1) m_moves++;
            end
         end
         void'(hist.pop_front());
         hist.push_back({n, s, e, w});
         push_expect();
      end
   end

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t x;
         x = exp_q.pop_front();
         check("scoreboard {room,sw,win,dead,moves}",
               32'({room, sw, win, dead, moves}),
               32'({x.room, x.sw, x.win, x.dead, x.moves}));
      end
   end

   task automatic press(input logic [3:0] m, input int hold, input int gap);
      @(negedge clk);
      {n, s, e, w} = m;
      repeat (hold) @(negedge clk);
      {n, s, e, w} = 4'b0000;
      repeat (gap) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b1;
      check("reset room", 32'(room), 32'h01);
      check("reset moves", 32'(moves), 32'd0);
      check("reset sw/win/dead", 32'({sw, win, dead}), 32'd0);

      // Latency: e rises before edge k, room changes at edge k+2.
      @(negedge clk);
      e = 1'b1;
      @(negedge clk);
      check("latency k", 32'(room), 32'h01);
      @(negedge clk);
      check("latency k+1", 32'(room), 32'h01);
      @(negedge clk);
      check("latency k+2", 32'(room), 32'h02);
      repeat (2) @(negedge clk);
      e = 1'b0;
      repeat (3) @(negedge clk);
      press(4'b0100, 5, 5);
      check("tunnel s -> river", 32'(room), 32'h04);
      press(4'b0001, 5, 5);
      check("river w -> stash", 32'(room), 32'h08);
      check("sw in stash", 32'(sw), 32'd1);
      check("moves after 3", 32'(moves), 32'd3);

      v = 1'b1;
      press(4'b0010, 5, 5);
      check("stash e -> river", 32'(room), 32'h04);
      press(4'b0010, 5, 5);
      check("den -> vault", 32'(room), 32'h20);
      check("win", 32'(win), 32'd1);
      check("moves at vault", 32'(moves), 32'd5);

      // Mid-cycle asynchronous reset while in RIVER.
      do_reset();
      press(4'b0010, 4, 4);
      press(4'b0100, 4, 4);
      check("back in river", 32'(room), 32'h04);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("async reset room", 32'(room), 32'h01);
      check("async reset moves", 32'(moves), 32'd0);
      check("async reset sw/win/dead", 32'({sw, win, dead}), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      v = 1'b0;
      press(4'b0010, 4, 4);
      press(4'b0100, 4, 4);
      press(4'b0010, 4, 4);
      check("den -> graveyard", 32'(room), 32'h40);
      check("dead", 32'(dead), 32'd1);
      press(4'b1000, 3, 3);
      press(4'b0010, 3, 3);
      press(4'b0001, 3, 3);
      check("graveyard terminal", 32'(room), 32'h40);
      check("graveyard moves", 32'(moves), 32'd3);

      do_reset();
      press(4'b0010, 4, 4);
      press(4'b0100, 20, 4);
      check("held s one move room", 32'(room), 32'h04);
      check("held s one move count", 32'(moves), 32'd2);
      press(4'b1010, 4, 4);
      check("simultaneous n+e room", 32'(room), 32'h04);
      check("simultaneous n+e moves", 32'(moves), 32'd2);

      do_reset();
      for (int i = 0; i < 300; i++) begin
         press(4'b0010, 2, 2);
         press(4'b0001, 2, 2);
      end
      check("saturated moves", 32'(moves), 32'd255);
      check("toggle ends in cave", 32'(room), 32'h01);

      do_reset();
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            @(negedge clk);
            #2 reset = 1'b0;
            repeat ($urandom_range(1, 2)) @(negedge clk);
            reset = 1'b1;
         end else begin
            logic [3:0] m;
            if ($urandom_range(0, 3) == 0) m = 4'($urandom_range(0, 15));
            else m = 4'(1 << $urandom_range(0, 3));
            v = 1'($urandom_range(0, 1));
            press(m, $urandom_range(1, 4), $urandom_range(0, 3));
         end
      end
      repeat (5) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/room_fsm.md
Name: room_fsm

Overview:
- Room-navigation FSM for the adventure-game datapath.
- Converts raw N/S/E/W direction buttons into one-step room moves and tracks the player's current room.
- Drives `sw` (player is in the Secret Sword Stash) into the sword-tracking stage.
- Consumes that stage's `v` (sword held) to resolve the Dragon's Den encounter.
- Also produces win/dead status, a one-hot room display and a move count.

Parameters:
- SYNC_STAGES, 2: number of synchronizer flops per direction input; legal range 2..4.
- MOVE_W, 8: width of the saturating move counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- n  input  1  north button, raw level, asynchronous to clk.
- s  input  1  south button, raw level.
- e  input  1  east button, raw level.
- w  input  1  west button, raw level.
- v  input  1  sword-held flag from the sword-tracking stage.
- sw  output  1  1 while the current room is SWORD_STASH.
- room  output  7  one-hot current room: bit0 CAVE, bit1 TUNNEL, bit2 RIVER, bit3 SWORD_STASH, bit4 DEN, bit5 VAULT, bit6 GRAVEYARD.
- win  output  1  1 while in VAULT.
- dead  output  1  1 while in GRAVEYARD.
- moves  output  MOVE_W  count of button-driven room changes.

Behaviour:
- Reset (`reset` = 0, asynchronous):
  - Room goes to CAVE, so `room` = 7'b0000001.
  - `sw`, `win` and `dead` are 0; `moves` is 0.
  - All synchronizer and edge-detect flops are cleared to 0.
- Direction input path:
  - Each direction passes through SYNC_STAGES flops, then one "previous" register.
  - A press is the synchronized level being 1 while the previous-register value is 0 (rising edge).
  - Room register updates on the same edge that loads the previous register.
  - Latency: an input held high before edge k changes `room` at edge k+SYNC_STAGES.
  - One press gives exactly one move; holding a button gives no further moves.
- Simultaneous presses: if more than one direction has a rising edge in the same cycle, no move occurs and `moves` is unchanged. Those edges are consumed.
- Transitions on a single valid press (any press not listed is ignored and the room is unchanged):
  - CAVE: e -> TUNNEL.
  - TUNNEL: s -> RIVER; w -> CAVE.
  - RIVER: n -> TUNNEL; w -> SWORD_STASH; e -> DEN.
  - SWORD_STASH: e -> RIVER.
  - DEN: all buttons ignored. On the next clock edge, `v` = 1 -> VAULT, `v` = 0 -> GRAVEYARD. `v` is sampled on that edge.
  - VAULT and GRAVEYARD: terminal. All buttons are ignored until reset.
- Move counter:
  - Increments by 1 on each button-driven room change.
  - The automatic DEN exit does not count.
  - Saturates at 2^MOVE_W-1; no wrap-around.
- Outputs:
  - `room`, `sw`, `win` and `dead` decode combinationally from the state register only. No input feeds through combinationally.
  - `sw` = 1 exactly while in SWORD_STASH, so the sword stage sees it for every cycle the player is in the stash.
- State encoding:
  - State is kept in a 3-bit encoded register.
  - Any unused encoding recovers to CAVE on the next edge.
- Reset mid-operation:
  - Takes effect immediately regardless of the clock.
  - A partially synchronized press is discarded.
  - A button held through reset deassertion is seen as one fresh press once it has propagated through the synchronizer.

Test Plan:
- Assert reset low mid-cycle while in RIVER -> `room` = 7'h01, `moves` = 0, `win`/`dead`/`sw` = 0 immediately, without waiting for a clock edge.
- From reset, press e, s, w as single pulses, each held 5 cycles with gaps -> `room` 7'h02, 7'h04, 7'h08 in turn. `sw` = 1 in the stash. `moves` = 3. Each change lands SYNC_STAGES (2) edges after the input rises.
- Walk to RIVER, press w then e (stash visit, `v` driven to 1 externally), then e again -> DEN for exactly 1 cycle, then `room` = 7'h20, `win` = 1, `moves` = 5.
- Walk to RIVER without visiting the stash (`v` = 0), press e -> DEN for 1 cycle, then `room` = 7'h40, `dead` = 1. Any further presses leave `room` = 7'h40 and `moves` = 3.
- In TUNNEL, hold s for 20 cycles -> exactly one move (to RIVER). Press n and e on the same cycle -> no move, `moves` unchanged.
- Toggle e/w between CAVE and TUNNEL 300 times with MOVE_W = 8 -> `moves` saturates at 255 and stays there.
